// File: rtl/mc_rv32_core.sv
// mc_rv32_core: multi-cycle RV32I-subset core with one shared ALU.
// FETCH/DECODE/EXEC/MEM/WB sequencing with on-chip IMEM, DMEM and register file.
// The PC is a word address. ECALL or an unsupported instruction halts the core.
// Optional feature: define MC_RV32_BNE_EN to decode bne (funct3=001).
module mc_rv32_core #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter int RET_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [31:0]        prog_data,
  input  logic [4:0]         dbg_reg_addr,
  output logic [31:0]        dbg_reg_data,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [IMEM_AW-1:0] pc,
  output logic [RET_W-1:0]   retired
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0] imem [2**IMEM_AW];
  logic [31:0] dmem [2**DMEM_AW];
  logic [31:0] rf   [32];

  logic [31:0] ir, opa, opb, imm, aluout, mdr;
  logic [31:0] imm_dec, alu_res;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic        is_ecall, is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_br;
  logic        legal, br_take;
  logic [IMEM_AW-1:0] pc_inc, pc_br;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : rf[dbg_reg_addr];

  // IMM is a byte offset; the word-addressed PC uses IMM>>>2, truncated to PC width.
  assign pc_inc = pc + IMEM_AW'(1);
  assign pc_br  = pc + imm[IMEM_AW+1:2];

  // Instruction classification from the held IR
  always_comb begin
    is_ecall = (ir == 32'h0000_0073);
    is_r     = 1'b0;
    if (opcode == 7'b0110011) begin
      if (f7 == 7'b0000000)
        is_r = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
      else if (f7 == 7'b0100000)
        is_r = (f3 == 3'b000);
    end
    is_addi = (opcode == 7'b0010011) && (f3 == 3'b000);
    is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
    is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
    is_beq  = (opcode == 7'b1100011) && (f3 == 3'b000);
`ifdef MC_RV32_BNE_EN
    is_bne  = (opcode == 7'b1100011) && (f3 == 3'b001);
`else
    is_bne  = 1'b0;
`endif
    is_br   = is_beq | is_bne;
    legal   = is_r | is_addi | is_lw | is_sw | is_br;
  end

  // Immediate extraction by format: S for stores, B for branches, I otherwise
  always_comb begin
    case (opcode)
      7'b0100011: imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:    imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  // Shared ALU: register ops for R-type, address/addi add otherwise; branch compare
  always_comb begin
    alu_res = opa + imm;
    if (is_r) begin
      case (f3)
        3'b000:  alu_res = f7[5] ? (opa - opb) : (opa + opb);
        3'b111:  alu_res = opa & opb;
        3'b110:  alu_res = opa | opb;
        3'b010:  alu_res = {31'd0, $signed(opa) < $signed(opb)};
        default: alu_res = opa + opb;
      endcase
    end
    br_take = is_bne ? (opa != opb) : (opa == opb);
  end

  // Next-state sequencing
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = (is_ecall || !legal) ? S_HALT : S_EXEC;
      S_EXEC:   state_nx = is_br ? S_FETCH : ((is_lw || is_sw) ? S_MEM : S_WB);
      S_MEM:    state_nx = is_lw ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register plus architectural and pipeline-internal registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      retired <= '0;
      illegal <= 1'b0;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      imm     <= '0;
      aluout  <= '0;
      mdr     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_HALT: if (start) begin
          pc      <= '0;
          retired <= '0;
          illegal <= 1'b0;
        end
        S_FETCH: ir <= imem[pc];
        S_DECODE: begin
          opa <= rf[rs1];
          opb <= rf[rs2];
          imm <= imm_dec;
          if (!is_ecall && !legal) illegal <= 1'b1;
        end
        S_EXEC: begin
          aluout <= alu_res;
          if (is_br) begin
            pc      <= br_take ? pc_br : pc_inc;
            retired <= retired + RET_W'(1);
          end
        end
        S_MEM: begin
          if (is_lw) mdr <= dmem[aluout[DMEM_AW+1:2]];
          else begin
            pc      <= pc_inc;
            retired <= retired + RET_W'(1);
          end
        end
        S_WB: begin
          pc      <= pc_inc;
          retired <= retired + RET_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Register file: cleared on reset, written in WB; x0 writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && rd != 5'd0) begin
      rf[rd] <= is_lw ? mdr : aluout;
    end
  end

  // Memories: program load only while not running; store commits on the MEM edge
  always_ff @(posedge clk) begin
    if (prog_we && !busy) imem[prog_addr] <= prog_data;
    if (state == S_MEM && is_sw) dmem[aluout[DMEM_AW+1:2]] <= opb;
  end
endmodule

// File: tb/tb_mc_rv32_core.sv
// tb_mc_rv32_core: ISA-level reference interpreter producing a per-cycle
// expectation queue (pc, retired, busy, halted, illegal) checked every cycle,
// plus directed programs with hand-computed results and random programs.
module tb_mc_rv32_core;
  localparam int IAW = 8;
  localparam int DAW = 8;
  localparam int RW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           prog_we = 1'b0;
  logic [IAW-1:0] prog_addr = '0;
  logic [31:0]    prog_data = '0;
  logic [4:0]     dbg_reg_addr = '0;
  logic [31:0]    dbg_reg_data;
  logic           busy, halted, illegal;
  logic [IAW-1:0] pc;
  logic [RW-1:0]  retired;

  mc_rv32_core #(.IMEM_AW(IAW), .DMEM_AW(DAW), .RET_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_data(dbg_reg_data), .busy(busy), .halted(halted),
    .illegal(illegal), .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IAW-1:0] pc;
    logic [RW-1:0]  ret;
    logic           busy;
    logic           halted;
    logic           ill;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  obs_t expq[$];
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_rf   [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic obs_t mk(input int p, input int r, input bit b, input bit h, input bit il);
    obs_t o;
    o.pc = IAW'(p); o.ret = RW'(r); o.busy = b; o.halted = h; o.ill = il;
    return o;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  // Per-cycle observation check whenever the model has expectations queued
  always @(negedge clk) begin : cmp
    obs_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.pc = pc; a.ret = retired; a.busy = busy; a.halted = halted; a.ill = illegal;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_obs @%0t: got pc=%0d ret=%0d busy=%b halted=%b ill=%b, expected pc=%0d ret=%0d busy=%b halted=%b ill=%b",
                 $time, a.pc, a.ret, a.busy, a.halted, a.ill, e.pc, e.ret, e.busy, e.halted, e.ill);
      end
    end
  end

  // Architectural interpreter: executes from pc 0, queuing one entry per clock
  task automatic model_run();
    int mpc, ret, steps, lat, npc, wr;
    bit ill, stop;
    logic [31:0] ir, a, b, immi, imms, immb, res, ea;
    mpc = 0; ret = 0; steps = 0;
    forever begin
      ir   = m_imem[mpc];
      a    = m_rf[ir[19:15]];
      b    = m_rf[ir[24:20]];
      immi = {{20{ir[31]}}, ir[31:20]};
      imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      lat = 4; npc = (mpc + 1) % 256; wr = -1; res = '0; ill = 0; stop = 0;
      case (ir[6:0])
        7'h33: begin
          wr = ir[11:7];
          case ({ir[31:25], ir[14:12]})
            {7'h00, 3'd0}: res = a + b;
            {7'h20, 3'd0}: res = a - b;
            {7'h00, 3'd7}: res = a & b;
            {7'h00, 3'd6}: res = a | b;
            {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ill = 1;
          endcase
        end
        7'h13: if (ir[14:12] == 3'd0) begin wr = ir[11:7]; res = a + immi; end else ill = 1;
        7'h03: if (ir[14:12] == 3'd2) begin
          ea = a + immi; wr = ir[11:7]; res = m_dmem[(ea >> 2) & 32'hFF]; lat = 5;
        end else ill = 1;
        7'h23: if (ir[14:12] != 3'd2) ill = 1;
        7'h63: begin
          lat = 3;
          if (ir[14:12] == 3'd0) begin
            if (a == b) npc = (mpc + ($signed(immb) >>> 2)) & 255;
`ifdef MC_RV32_BNE_EN
          end else if (ir[14:12] == 3'd1) begin
            if (a != b) npc = (mpc + ($signed(immb) >>> 2)) & 255;
`endif
          end else ill = 1;
        end
        7'h73: if (ir == 32'h73) stop = 1; else ill = 1;
        default: ill = 1;
      endcase
      if (ill || stop) begin
        expq.push_back(mk(mpc, ret, 1, 0, 0));
        expq.push_back(mk(mpc, ret, 1, 0, 0));
        expq.push_back(mk(mpc, ret, 0, 1, ill));
        break;
      end
      if (ir[6:0] == 7'h23) m_dmem[((a + imms) >> 2) & 32'hFF] = b;
      repeat (lat) expq.push_back(mk(mpc, ret, 1, 0, 0));
      if (wr > 0) m_rf[wr] = res;
      mpc = npc; ret++; steps++;
      if (steps > 5000) begin
        $display("model step limit hit");
        break;
      end
    end
  endtask

  task automatic fill_imem(input logic [31:0] w);
    for (int i = 0; i < 256; i++) m_imem[i] = w;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = IAW'(i); prog_data = m_imem[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic rd_reg(input int r, output logic [31:0] v);
    dbg_reg_addr = 5'(r);
    #1 v = dbg_reg_data;
  endtask

  task automatic check_regs();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      rd_reg(r, v);
      chk($sformatf("reg_x%0d", r), v, (r == 0) ? 32'd0 : m_rf[r]);
    end
  endtask

  // Pulse start, let the model queue the timeline, wait (bounded) for halt
  task automatic run_prog(output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_run();
    lat = -1;
    for (int k = 1; k <= 20000; k++) begin
      @(posedge clk); #1;
      if (halted) begin lat = k; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got no halt, expected halt within 20000 cycles");
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    expq.delete();
    check_regs();
  endtask

  task automatic chk_reset_vals(input string tag);
    logic [31:0] v;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
    rd_reg(1, v);
    chk({tag, "_x1"}, v, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    expq.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start a run and pull reset a couple of ns after the given number of edges
  task automatic abort_after(input int edges, input string tag);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (edges) @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    #1 chk_reset_vals(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic prog_t1();
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13);
    m_imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
  endtask

  task automatic gen_random();
    int n, kind, sel;
    logic [4:0] rd, rs1, rs2;
    logic [11:0] im;
    logic [2:0] rf3 [5];
    logic [6:0] rf7 [5];
    rf3 = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd2};
    rf7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
    fill_imem(32'h73);
    n = $urandom_range(10, 40);
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 99);
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      im = 12'($urandom);
      if (kind < 40) begin
        sel = $urandom_range(0, 4);
        m_imem[i] = enc_r(rf7[sel], rs2, rs1, rf3[sel], rd);
      end else if (kind < 55) m_imem[i] = enc_i(im, rs1, 3'd0, rd, 7'h13);
      else if (kind < 68) m_imem[i] = enc_i(im, rs1, 3'd2, rd, 7'h03);
      else if (kind < 81) m_imem[i] = enc_s(im, rs2, rs1);
      else if (kind < 91) m_imem[i] = enc_b(13'($urandom_range(1, 4) * 4), rs2, rs1, 3'd0);
      else if (kind < 98) m_imem[i] = enc_b(13'($urandom_range(1, 4) * 4), rs2, rs1, 3'd1);
      else m_imem[i] = $urandom;
    end
  endtask

  initial begin : main
    int lat;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) m_dmem[i] = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;

    repeat (3) @(negedge clk);
    #1 chk_reset_vals("por");
    rst_n = 1'b1;

    // add of two immediates
    prog_t1();
    load_prog();
    run_prog(lat);
    chk("t1_latency", 32'(lat), 32'd14);
    rd_reg(3, v); chk("t1_x3", v, 32'd12);
    chk("t1_retired", 32'(retired), 32'd3);
    chk("t1_pc", 32'(pc), 32'd3);
    chk("t1_illegal", 32'(illegal), 32'd0);

    // signed slt and sub
    do_reset();
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'hFFD, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'h13);
    m_imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3);
    m_imem[3] = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);
    load_prog();
    run_prog(lat);
    rd_reg(3, v); chk("t2_x3", v, 32'd1);
    rd_reg(4, v); chk("t2_x4", v, 32'd5);

    // store/load round trip and x0 write discard
    do_reset();
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'd42, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_s(12'd8, 5'd1, 5'd0);
    m_imem[2] = enc_i(12'd8, 5'd0, 3'd2, 5'd2, 7'h03);
    m_imem[3] = enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13);
    load_prog();
    run_prog(lat);
    chk("t3_latency", 32'(lat), 32'd19);
    rd_reg(2, v); chk("t3_x2", v, 32'd42);
    rd_reg(0, v); chk("t3_x0", v, 32'd0);
    chk("t3_retired", 32'(retired), 32'd4);

    // taken beq skips one instruction
    do_reset();
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_b(13'd8, 5'd1, 5'd1, 3'd0);
    m_imem[2] = enc_i(12'd99, 5'd0, 3'd0, 5'd2, 7'h13);
    load_prog();
    run_prog(lat);
    rd_reg(2, v); chk("t4_x2", v, 32'd0);
    chk("t4_retired", 32'(retired), 32'd2);
    chk("t4_pc", 32'(pc), 32'd3);

    // unknown opcode halts illegal, then a clean rerun clears it
    fill_imem(32'h73);
    m_imem[0] = 32'h0000_007F;
    load_prog();
    run_prog(lat);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_illegal", 32'(illegal), 32'd1);
    chk("t5_retired", 32'(retired), 32'd0);
    prog_t1();
    load_prog();
    run_prog(lat);
    chk("t5_illegal_cleared", 32'(illegal), 32'd0);

    // zero all of DMEM with a backward-branch loop
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'd0, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_i(12'h400, 5'd0, 3'd0, 5'd3, 7'h13);
    m_imem[2] = enc_s(12'd0, 5'd0, 5'd1);
    m_imem[3] = enc_i(12'd4, 5'd1, 3'd0, 5'd1, 7'h13);
    m_imem[4] = enc_b(13'd8, 5'd3, 5'd1, 3'd0);
    m_imem[5] = enc_b(13'h1FF4, 5'd0, 5'd0, 3'd0);
    load_prog();
    run_prog(lat);
    chk("init_retired", 32'(retired), 32'd1025);

    // reset during EXEC of the first instruction, then rerun
    prog_t1();
    load_prog();
    abort_after(2, "abort_exec");
    run_prog(lat);
    rd_reg(3, v); chk("abort_rerun_x3", v, 32'd12);

    // reset during EXEC of a store: the store must not land
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'd77, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_s(12'd12, 5'd1, 5'd0);
    load_prog();
    abort_after(6, "abort_sw");
    fill_imem(32'h73);
    m_imem[0] = enc_i(12'd12, 5'd0, 3'd2, 5'd2, 7'h03);
    load_prog();
    run_prog(lat);
    rd_reg(2, v); chk("abort_sw_dmem", v, 32'd0);

    // prog_we and start while busy are ignored
    prog_t1();
    load_prog();
    fork
      run_prog(lat);
      begin
        repeat (4) @(negedge clk);
        prog_we = 1'b1; prog_addr = '0; prog_data = 32'h0000_007F; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
      end
    join
    run_prog(lat);
    chk("busy_we_illegal", 32'(illegal), 32'd0);
    rd_reg(3, v); chk("busy_we_x3", v, 32'd12);

    // random programs
    for (int t = 0; t < 25; t++) begin
      gen_random();
      load_prog();
      run_prog(lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_rv32_core.md
Name: mc_rv32_core

Overview:
- Parametrised multi-cycle RV32I-subset core; successor to the single-cycle datapath.
- Shares one ALU across FETCH/DECODE/EXEC/MEM/WB states, driven by an explicit FSM.
- Contains its own instruction memory, data memory, register file and architectural-state registers.
- Programs are loaded through a write port; execution starts on a start pulse and ends on ECALL or an illegal instruction.

Parameters:
- IMEM_AW, 8, instruction-memory word-address width; depth 2**IMEM_AW; PC is IMEM_AW bits, word-addressed.
- DMEM_AW, 8, data-memory word-address width; depth 2**DMEM_AW.
- RET_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- prog_we  in  1  IMEM write enable; honoured only in IDLE or HALT.
- prog_addr  in  IMEM_AW  IMEM write word address.
- prog_data  in  32  IMEM write data.
- dbg_reg_addr  in  5  register-file debug read address.
- dbg_reg_data  out  32  combinational read of x[dbg_reg_addr]; x0 reads 0.
- busy  out  1  high in any state other than IDLE/HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when halt is caused by an unsupported instruction.
- pc  out  IMEM_AW  current PC.
- retired  out  RET_W  count of completed instructions; ECALL and illegal instructions are not counted; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, retired=0, illegal=0, busy=0, halted=0.
  - Register file cleared to 0.
  - IMEM/DMEM contents are not reset.
- IDLE/HALT + start: pc<=0, illegal<=0, retired<=0, next state FETCH. DMEM and registers are kept.
- FETCH: IR<=IMEM[pc]; -> DECODE.
- DECODE: A<=x[rs1], B<=x[rs2], IMM<=sign-extended immediate.
  - ECALL (0x00000073) -> HALT.
  - Unsupported opcode/funct -> HALT, illegal<=1.
  - Otherwise -> EXEC.
- EXEC:
  - R-type add/sub/and/or/slt (signed): ALUOUT<=A op B; -> WB.
  - addi: ALUOUT<=A+IMM; -> WB.
  - lw/sw: ALUOUT<=A+IMM; -> MEM.
  - beq: if A==B, pc<=pc+(IMM>>>2), else pc<=pc+1; retired++; -> FETCH.
- MEM:
  - lw: MDR<=DMEM[ALUOUT[DMEM_AW+1:2]]; -> WB.
  - sw: DMEM[ALUOUT[DMEM_AW+1:2]]<=B; pc<=pc+1; retired++; -> FETCH.
- WB: x[rd]<=(lw ? MDR : ALUOUT); pc<=pc+1; retired++; -> FETCH.
- Latency in cycles: ALU ops 4, lw 5, sw 4, beq 3, ECALL 2 to HALT.
- Writes to x0 are discarded.
- PC arithmetic wraps modulo 2**IMEM_AW.
- Byte-address bits [1:0] are ignored; the data address truncates to DMEM_AW bits (wraps).
- A prog_we or start asserted while busy is ignored.
- rst_n falling mid-instruction aborts immediately to the reset state. A pending DMEM write is not performed if reset precedes the MEM edge.

Optional Feature:
- MC_RV32_BNE_EN
  - Defined: bne (funct3=001) is decoded; it behaves like beq with the inverted condition and the same 3-cycle latency.
  - Undefined: bne is unsupported -> HALT with illegal=1.

Test Plan:
- Reset, then load addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; ecall; pulse start -> halted rises 14 cycles after the start edge; x3=12, retired=3, illegal=0, pc=3.
- addi x1,x0,-3; addi x2,x0,2; slt x3,x1,x2; sub x4,x2,x1; ecall -> x3=1, x4=5.
- addi x1,x0,42; sw x1,8(x0); lw x2,8(x0); addi x0,x0,9; ecall -> x2=42, x0 reads 0, retired=4.
- addi x1,x0,1; beq x1,x1,+8; addi x2,x0,99; ecall -> x2 remains 0; the skipped instruction is not executed.
- Word 0x0000007F (unknown opcode) at pc 0 -> halted=1, illegal=1, retired=0. Then reload and pulse start -> illegal clears.
- Deassert rst_n during the EXEC of the first instruction -> all outputs return to reset values immediately. Start again -> program reruns correctly. prog_we while busy -> IMEM is unchanged.
